m_uart_wbinit: RTL and testbench
================================

M_UART_WBINIT -- requirements
Module: m_uart_wbinit

Interface
REQ-001 Parameter CLKDIV, default 104, CLK_I cycles per UART bit (12 MHz / 115200); legal range 8..4095.
REQ-002 Parameter ACKTMO, default 255, maximum CLK_I cycles to wait for ACK_I before aborting a bus cycle.
REQ-003 CLK_I  input  1  the single clock; all state changes on its rising edge.
REQ-004 RST_I  input  1  reset, synchronous and active-low.
REQ-005 usartRX  input  1  serial command input, 8N1, idle high, asynchronous to CLK_I.
REQ-006 usartTX  output  1  serial reply output, 8N1, idle high.
REQ-007 CYC_O, STB_O  output  1 each  Wishbone initiator cycle and strobe.
REQ-008 WE_O  output  1  Wishbone write enable.
REQ-009 ADR_O  output  32  Wishbone byte address.
REQ-010 DAT_O  output  32  Wishbone write data.
REQ-011 SEL_O  output  4  Wishbone byte selects.
REQ-012 ACK_I  input  1  Wishbone acknowledge from the addressed responder.
REQ-013 DAT_I  input  32  Wishbone read data.
REQ-014 busy  output  1  high from the first command byte accepted until the last reply stop bit ends.

Function
REQ-015 usartRX passes through a 2-flop synchronizer before any use.
REQ-016 RX: a high-to-low transition while idle starts a frame; the start bit is resampled at CLKDIV/2, and a high sample there returns RX to idle with no byte delivered.
REQ-017 RX samples the 8 data bits LSB first at CLKDIV intervals after the start-bit midpoint, then the stop bit; a stop bit sampled low is a framing error and discards the byte.
REQ-018 TX sends a start bit (0), 8 data bits LSB first, and a stop bit (1), each exactly CLKDIV cycles long; usartTX is high whenever TX is idle.
REQ-019 Command FSM states: IDLE, GETADR, GETDAT, BUS, REPLY.
REQ-020 In IDLE, byte 0x57 ('W') enters GETADR for a write, byte 0x52 ('R') enters GETADR for a read, and any other byte sends the single reply byte 0x15.
REQ-021 GETADR collects 4 bytes LSB first into ADR_O, then enters GETDAT for a write or BUS for a read.
REQ-022 GETDAT collects 4 bytes LSB first into DAT_O, then enters BUS.
REQ-023 BUS asserts CYC_O=STB_O=1 and SEL_O=4'hF (WE_O=1 for a write, 0 for a read) in the cycle after entry, and holds them stable until ACK_I or timeout.
REQ-024 On the first cycle ACK_I=1 during BUS, the FSM deasserts CYC_O and STB_O on the next edge and, for a read, latches DAT_I.
REQ-025 A bus cycle lasts at most ACKTMO cycles; if ACK_I has not arrived by then, the cycle is dropped and the reply is 0x15.
REQ-026 Write reply is the single byte 0x06; read reply is the 4 latched data bytes, LSB first.
REQ-027 RX bytes received while in BUS or REPLY are discarded; no queuing.
REQ-028 Inter-byte gaps are unlimited; there is no command timeout.
REQ-029 ACK_I is ignored whenever STB_O=0.
REQ-030 WE_O, ADR_O and DAT_O are held at their last values while CYC_O=0.

Reset
REQ-031 While RST_I=0: usartTX=1, CYC_O=0, STB_O=0, WE_O=0, SEL_O=0, ADR_O=0, DAT_O=0, busy=0, FSM=IDLE, and RX and TX are idle.
REQ-032 A reset in the middle of a frame or bus cycle aborts it immediately and discards any partial byte or command.
REQ-033 After RST_I rises, the first falling edge on usartRX is accepted no earlier than the third CLK_I edge (synchronizer depth).

Structure
REQ-034 Command and reply codes (0x57, 0x52, 0x06, 0x15) are shared constants, defined in the common include used by the codebase's hardware-test tops.
REQ-035 A single sub-module, m_uart_wbinit_phy, holds the RX and TX shifters and bit timers; the command FSM stays in m_uart_wbinit.

Verification
REQ-036 Send 57 10 00 00 60 EF BE AD DE with the responder acking after 2 cycles -> exactly one cycle with ADR_O=32'h6000_0010, DAT_O=32'hDEAD_BEEF, WE_O=1, SEL_O=F, then TX byte 0x06.
REQ-037 Send 52 08 00 00 60 with the responder returning DAT_I=32'h0000_0100 -> WE_O=0 read at 32'h6000_0008, then TX bytes 00 01 00 00.
REQ-038 Send 0x41 -> no bus cycle and TX byte 0x15; a following valid 'R' command completes normally.
REQ-039 Send a write command with ACK_I held at 0 -> CYC_O drops after ACKTMO=255 cycles and TX byte 0x15.
REQ-040 Send a byte with its stop bit forced low, then a 1/4-bit glitch on usartRX -> no byte accepted, busy stays 0.
REQ-041 Pull RST_I low in the middle of GETDAT, then release it -> all outputs at their reset values and the next full 'W' command executes correctly.

Source files
------------

// File: rtl/m_uart_wbinit_pkg.sv
// Shared constants and types for the UART-to-Wishbone bridge.
package m_uart_wbinit_pkg;

  // Command and reply codes exchanged over the serial link.
  localparam logic [7:0] CmdWrite = 8'h57;  // 'W'
  localparam logic [7:0] CmdRead  = 8'h52;  // 'R'
  localparam logic [7:0] RspAck   = 8'h06;
  localparam logic [7:0] RspNak   = 8'h15;

  typedef enum logic [2:0] {
    StIdle,
    StGetAdr,
    StGetDat,
    StBus,
    StReply
  } cmd_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  typedef enum logic {
    TxIdle,
    TxSend
  } tx_state_e;

  // Multi-byte fields arrive LSB first; each new byte enters at the top.
  function automatic logic [31:0] shift_in_byte(input logic [31:0] acc, input logic [7:0] b);
    return {b, acc[31:8]};
  endfunction

endpackage

// File: rtl/m_uart_wbinit_phy.sv
// 8N1 UART receiver and transmitter with shared bit period CLKDIV.
module m_uart_wbinit_phy
  import m_uart_wbinit_pkg::*;
#(
  parameter int unsigned CLKDIV = 104
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       usartRX,
  output logic       usartTX,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy
);

  localparam int unsigned CntW = $clog2(CLKDIV);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKDIV - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKDIV / 2 - 1);

  // [1] is the synchronized line, [2] its previous value for edge detection.
  logic [2:0]      rx_sync_q;
  rx_state_e       rx_state_q;
  logic [CntW-1:0] rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_sh_q;

  tx_state_e       tx_state_q;
  logic [CntW-1:0] tx_cnt_q;
  logic [3:0]      tx_bit_q;
  logic [8:0]      tx_sh_q;

  logic rx_s;
  assign rx_s    = rx_sync_q[1];
  assign tx_busy = (tx_state_q == TxSend);

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) rx_sync_q <= 3'b111;
    else        rx_sync_q <= {rx_sync_q[1:0], usartRX};
  end

  // Receiver: validate start at mid-bit, then sample data and stop at bit centres.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state_q)
        RxIdle: begin
          if (rx_sync_q[2] && !rx_s) begin
            rx_state_q <= RxStart;
            rx_cnt_q   <= '0;
          end
        end
        RxStart: begin
          if (rx_cnt_q == HalfLast) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s ? RxIdle : RxData;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (rx_cnt_q == BitLast) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_s, rx_sh_q[7:1]};
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (rx_cnt_q == BitLast) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RxIdle;
            // A low stop bit is a framing error: drop the byte silently.
            if (rx_s) begin
              rx_valid <= 1'b1;
              rx_data  <= rx_sh_q;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // Transmitter: start bit, 8 data bits LSB first, stop bit, each CLKDIV cycles.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      usartTX    <= 1'b1;
    end else begin
      case (tx_state_q)
        TxIdle: begin
          usartTX <= 1'b1;
          if (tx_start) begin
            tx_sh_q    <= {1'b1, tx_data};
            usartTX    <= 1'b0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_state_q <= TxSend;
          end
        end
        TxSend: begin
          if (tx_cnt_q == BitLast) begin
            tx_cnt_q <= '0;
            // Bit 9 is the stop bit; its end returns the line to idle.
            if (tx_bit_q == 4'd9) begin
              tx_state_q <= TxIdle;
            end else begin
              usartTX  <= tx_sh_q[0];
              tx_sh_q  <= {1'b0, tx_sh_q[8:1]};
              tx_bit_q <= tx_bit_q + 4'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

endmodule

// File: rtl/m_uart_wbinit.sv
// UART command interpreter driving a single-beat Wishbone initiator.
module m_uart_wbinit
  import m_uart_wbinit_pkg::*;
#(
  parameter int unsigned CLKDIV = 104,
  parameter int unsigned ACKTMO = 255
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        usartRX,
  output logic        usartTX,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  input  logic        ACK_I,
  input  logic [31:0] DAT_I,
  output logic        busy
);

  localparam int unsigned TmoW = $clog2(ACKTMO + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(ACKTMO - 1);

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_busy;

  cmd_state_e      state_q;
  logic            is_wr_q;
  logic [1:0]      byte_cnt_q;
  logic [31:0]     adr_sh_q;
  logic [31:0]     dat_sh_q;
  logic [TmoW-1:0] tmo_q;
  logic [31:0]     reply_q;
  logic [2:0]      reply_left_q;
  logic            tx_start_q;
  logic [7:0]      tx_data_q;

  m_uart_wbinit_phy #(
    .CLKDIV(CLKDIV)
  ) u_phy (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .usartRX (usartRX),
    .usartTX (usartTX),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .tx_start(tx_start_q),
    .tx_data (tx_data_q),
    .tx_busy (tx_busy)
  );

  // Command FSM: collect address/data, run one bus cycle, stream the reply.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state_q      <= StIdle;
      is_wr_q      <= 1'b0;
      byte_cnt_q   <= '0;
      adr_sh_q     <= '0;
      dat_sh_q     <= '0;
      tmo_q        <= '0;
      reply_q      <= '0;
      reply_left_q <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      CYC_O        <= 1'b0;
      STB_O        <= 1'b0;
      WE_O         <= 1'b0;
      ADR_O        <= '0;
      DAT_O        <= '0;
      SEL_O        <= '0;
      busy         <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (rx_valid) begin
            busy       <= 1'b1;
            byte_cnt_q <= '0;
            if (rx_data == CmdWrite) begin
              is_wr_q <= 1'b1;
              state_q <= StGetAdr;
            end else if (rx_data == CmdRead) begin
              is_wr_q <= 1'b0;
              state_q <= StGetAdr;
            end else begin
              reply_q      <= {24'h0, RspNak};
              reply_left_q <= 3'd1;
              state_q      <= StReply;
            end
          end
        end
        StGetAdr: begin
          if (rx_valid) begin
            adr_sh_q   <= shift_in_byte(adr_sh_q, rx_data);
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              if (is_wr_q) begin
                state_q <= StGetDat;
              end else begin
                // Reads launch straight away; DAT_O keeps its last value.
                state_q <= StBus;
                tmo_q   <= '0;
                CYC_O   <= 1'b1;
                STB_O   <= 1'b1;
                SEL_O   <= 4'hF;
                WE_O    <= 1'b0;
                ADR_O   <= shift_in_byte(adr_sh_q, rx_data);
              end
            end
          end
        end
        StGetDat: begin
          if (rx_valid) begin
            dat_sh_q   <= shift_in_byte(dat_sh_q, rx_data);
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q <= StBus;
              tmo_q   <= '0;
              CYC_O   <= 1'b1;
              STB_O   <= 1'b1;
              SEL_O   <= 4'hF;
              WE_O    <= 1'b1;
              ADR_O   <= adr_sh_q;
              DAT_O   <= shift_in_byte(dat_sh_q, rx_data);
            end
          end
        end
        StBus: begin
          if (ACK_I && STB_O) begin
            CYC_O   <= 1'b0;
            STB_O   <= 1'b0;
            state_q <= StReply;
            if (is_wr_q) begin
              reply_q      <= {24'h0, RspAck};
              reply_left_q <= 3'd1;
            end else begin
              reply_q      <= DAT_I;
              reply_left_q <= 3'd4;
            end
          end else if (tmo_q == TmoLast) begin
            CYC_O        <= 1'b0;
            STB_O        <= 1'b0;
            reply_q      <= {24'h0, RspNak};
            reply_left_q <= 3'd1;
            state_q      <= StReply;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StReply: begin
          // tx_start_q guards the one cycle before the PHY reports busy.
          if (!tx_busy && !tx_start_q) begin
            if (reply_left_q == 3'd0) begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end else begin
              tx_start_q   <= 1'b1;
              tx_data_q    <= reply_q[7:0];
              reply_q      <= {8'h0, reply_q[31:8]};
              reply_left_q <= reply_left_q - 3'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_m_uart_wbinit.sv
// Bench for m_uart_wbinit: directed and random commands against a memory model.
module tb_m_uart_wbinit;

  localparam int unsigned DIV = 16;
  localparam int unsigned TMO = 255;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        tx;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_o;
  logic [3:0]  sel;
  logic        ack = 1'b0;
  logic [31:0] dat_i = 32'h0;
  logic        busy;

  int unsigned n_pass = 0;
  int unsigned n_fail = 0;
  int unsigned n_total = 0;

  logic [7:0]  txq[$];
  int unsigned tx_ferr = 0;
  txn_t        busq[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] exp_mem[logic [31:0]];
  bit          ack_en = 1'b1;
  int unsigned ack_dly = 2;
  int unsigned cyc_cnt = 0;
  int unsigned busy_cycles = 0;

  m_uart_wbinit #(
    .CLKDIV(DIV),
    .ACKTMO(TMO)
  ) dut (
    .CLK_I  (clk),
    .RST_I  (rst_n),
    .usartRX(rx),
    .usartTX(tx),
    .CYC_O  (cyc),
    .STB_O  (stb),
    .WE_O   (we),
    .ADR_O  (adr),
    .DAT_O  (dat_o),
    .SEL_O  (sel),
    .ACK_I  (ack),
    .DAT_I  (dat_i),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Contents of never-written locations.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  always @(negedge clk) begin
    if (cyc === 1'b1) cyc_cnt <= cyc_cnt + 1;
    if (busy === 1'b1) busy_cycles <= busy_cycles + 1;
  end

  // Wishbone responder backed by mem[], acking ack_dly cycles after the strobe.
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      if (cyc === 1'b1 && stb === 1'b1 && ack_en) begin
        t.adr = adr; t.dat = dat_o; t.we = we; t.sel = sel;
        busq.push_back(t);
        if (we === 1'b1) mem[adr] = dat_o;
        repeat (ack_dly) @(negedge clk);
        ack = 1'b1;
        dat_i = mem.exists(adr) ? mem[adr] : dflt(adr);
        @(negedge clk);
        ack = 1'b0;
        dat_i = $urandom;
      end
    end
  end

  // Serial decoder for the reply line.
  initial begin
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && tx === 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        if (tx !== 1'b1) tx_ferr++;
        txq.push_back(b);
      end
      prev = tx;
    end
  end

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: observed no finish, expected finish within 200000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = bad_stop ? 1'b0 : 1'b1;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " usartTX"}, 32'(tx), 32'd1);
    chk({tag, " CYC_O"}, 32'(cyc), 32'd0);
    chk({tag, " STB_O"}, 32'(stb), 32'd0);
    chk({tag, " WE_O"}, 32'(we), 32'd0);
    chk({tag, " SEL_O"}, 32'(sel), 32'd0);
    chk({tag, " ADR_O"}, adr, 32'd0);
    chk({tag, " DAT_O"}, dat_o, 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  // Send one command and compare reply bytes and bus activity with the model.
  task automatic run_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                         input string tag);
    logic [7:0]  exp_q[$];
    logic [31:0] rd;
    int unsigned nb0, cyc0, busy0, exp_bus;
    bit          is_cmd;
    txn_t        t;
    is_cmd = (op == 8'h57) || (op == 8'h52);
    txq.delete();
    nb0 = busq.size(); cyc0 = cyc_cnt; busy0 = busy_cycles;
    send_byte(op, 1'b0);
    if (is_cmd) for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b0);
    if (op == 8'h57) for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b0);

    if (is_cmd && !ack_en) begin
      exp_q.push_back(8'h15);
    end else if (op == 8'h57) begin
      exp_q.push_back(8'h06);
      exp_mem[a] = d;
    end else if (op == 8'h52) begin
      rd = exp_mem.exists(a) ? exp_mem[a] : dflt(a);
      for (int i = 0; i < 4; i++) exp_q.push_back(rd[8*i +: 8]);
    end else begin
      exp_q.push_back(8'h15);
    end
    exp_bus = (is_cmd && ack_en) ? 1 : 0;

    for (int k = 0; k < 20000 && (txq.size() < exp_q.size() || busy !== 1'b0); k++)
      @(negedge clk);
    repeat (2 * DIV) @(negedge clk);

    chk({tag, " reply count"}, txq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s reply byte %0d", tag, i),
          (i < txq.size()) ? {24'h0, txq[i]} : 32'hFFFF_FFFF, {24'h0, exp_q[i]});
    chk({tag, " bus cycles"}, busq.size() - nb0, exp_bus);
    if (exp_bus == 1 && busq.size() > nb0) begin
      t = busq[busq.size()-1];
      chk({tag, " ADR_O"}, t.adr, a);
      chk({tag, " WE_O"}, 32'(t.we), 32'(op == 8'h57));
      chk({tag, " SEL_O"}, 32'(t.sel), 32'hF);
      if (op == 8'h57) chk({tag, " DAT_O"}, t.dat, d);
    end
    if (is_cmd) begin
      chk({tag, " CYC_O length"}, cyc_cnt - cyc0, ack_en ? ack_dly + 1 : TMO);
      chk({tag, " ADR_O held"}, adr, a);
    end
    chk({tag, " busy seen"}, 32'(busy_cycles != busy0), 32'd1);
    chk({tag, " busy end"}, 32'(busy), 32'd0);
    chk({tag, " tx framing"}, tx_ferr, 32'd0);
  endtask

  initial begin
    logic [7:0]  op;
    logic [31:0] a, d;
    int unsigned nb0, busy0;

    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    ack_dly = 2;
    run_cmd(8'h57, 32'h6000_0010, 32'hDEAD_BEEF, "write");

    mem[32'h6000_0008] = 32'h0000_0100;
    exp_mem[32'h6000_0008] = 32'h0000_0100;
    run_cmd(8'h52, 32'h6000_0008, 32'h0, "read");

    run_cmd(8'h41, 32'h0, 32'h0, "bad op");
    run_cmd(8'h52, 32'h6000_0010, 32'h0, "read after bad op");

    ack_en = 1'b0;
    run_cmd(8'h57, 32'h6000_0020, $urandom, "timeout");
    ack_en = 1'b1;

    // Framing error then a short glitch: neither may start a command.
    txq.delete();
    nb0 = busq.size(); busy0 = busy_cycles;
    send_byte(8'h57, 1'b1);
    repeat (DIV) @(negedge clk);
    rx = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    rx = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    chk("noise busy", busy_cycles - busy0, 32'd0);
    chk("noise reply", txq.size(), 32'd0);
    chk("noise bus", busq.size() - nb0, 32'd0);

    // Reset in the middle of the data phase.
    send_byte(8'h57, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i), 1'b0);
    repeat (DIV) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("mid reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run_cmd(8'h57, 32'h6000_0030, 32'h1234_5678, "write after reset");
    run_cmd(8'h52, 32'h6000_0030, 32'h0, "read after reset");

    for (int n = 0; n < 8; n++) begin
      ack_dly = $urandom_range(0, 6);
      a = 32'h6000_0000 | (32'($urandom_range(0, 7)) << 2);
      d = $urandom;
      case ($urandom_range(0, 2))
        0: op = 8'h57;
        1: op = 8'h52;
        default: begin
          op = 8'($urandom);
          while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
        end
      endcase
      run_cmd(op, a, d, $sformatf("rand%0d op%02h", n, op));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
